// File: rtl/ntt_pkg.sv
// Shared NTT/INTT helpers: transform mode type, level-counter width, and the
// per-butterfly mask, swap-bit and twiddle-start functions. The butterfly
// datapath and the memory controller use the same functions so all three
// agree on the operand pairing.
package ntt_pkg;

  typedef enum logic {
    MODE_NTT  = 1'b0,
    MODE_INTT = 1'b1
  } ntt_mode_e;

  // Width of the level counter; never zero so the port stays legal for tiny N.
  function automatic int unsigned ntt_level_w(input int unsigned log_n);
    return (log_n <= 1) ? 1 : $clog2(log_n);
  endfunction

  // XOR mask that maps operand 0 index j to operand 1 index at level lvl.
  function automatic int unsigned ntt_mask(input ntt_mode_e md, input int unsigned log_n,
                                           input int unsigned lvl);
    int unsigned ones;
    ones = (32'd1 << lvl) - 32'd1;
    return (md == MODE_NTT) ? (ones << (log_n - 1 - lvl)) : ones;
  endfunction

  // Bank swap for the read side of a butterfly.
  function automatic logic ntt_rd_swap(input ntt_mode_e md, input int unsigned log_n,
                                       input int unsigned lvl, input int unsigned j);
    int unsigned pos;
    if (lvl == 0) return 1'b0;
    pos = (md == MODE_NTT) ? (log_n - 1 - lvl) : (lvl - 1);
    return 1'((j >> pos) & 32'd1);
  endfunction

  // Bank swap for the write-back side: the bit the next level will read on.
  function automatic logic ntt_wr_swap(input ntt_mode_e md, input int unsigned log_n,
                                       input int unsigned lvl, input int unsigned j);
    int unsigned pos;
    if (lvl >= log_n - 1) return 1'b0;
    pos = (md == MODE_NTT) ? (log_n - 2 - lvl) : lvl;
    return 1'((j >> pos) & 32'd1);
  endfunction

  // Twiddle start index; INTT walks the levels in mirrored order.
  function automatic int unsigned ntt_tw_start(input ntt_mode_e md, input int unsigned log_n,
                                               input int unsigned lvl, input int unsigned j);
    int unsigned l;
    l = (md == MODE_NTT) ? lvl : (log_n - 1 - lvl);
    return ((j >> (log_n - 1 - l)) << (log_n - l)) & ((32'd1 << log_n) - 32'd1);
  endfunction

endpackage

// File: rtl/ntt_delay_line.sv
// Fixed-latency delay line with two selectable taps and synchronous clear.
// A bundle sampled from din at edge e appears on the registered dout after
// edge e + TAP - 1 (TAP = 1 behaves as a single register).
// Ports: clk, clr (sync clear), sel (0 -> TAP_A, 1 -> TAP_B), din, dout.
module ntt_delay_line #(
  parameter int unsigned W     = 1,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAP_A = 1,
  parameter int unsigned TAP_B = 2
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         sel,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  // Shift stages; the output register provides the final cycle of delay.
  localparam int unsigned NS = (DEPTH > 1) ? DEPTH - 1 : 1;

  logic [W-1:0] stg [NS];
  logic [W-1:0] pick;
  int unsigned  tap;

  // Tap select: tap 1 bypasses the shift stages.
  always_comb begin
    tap  = sel ? TAP_B : TAP_A;
    pick = din;
    for (int unsigned i = 0; i < NS; i++) begin
      if (i + 2 == tap) pick = stg[i];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int unsigned i = 0; i < NS; i++) stg[i] <= '0;
      dout <= '0;
    end else begin
      stg[0] <= din;
      for (int unsigned i = 1; i < NS; i++) stg[i] <= stg[i-1];
      dout <= pick;
    end
  end

endmodule

// File: rtl/ntt_addr_gen.sv
// NTT/INTT butterfly address and control sequencer. After start it issues one
// butterfly per cycle over LOG_N levels of 2^(LOG_N-1) butterflies, then drains
// the write-back delay line and pulses done.
// Ports: clk, rst (sync, active-high), start/mode/addr_bias (latched in IDLE),
//   stall (only with NTT_ADDR_STALL_EN), busy, done, rd_valid, rd_addr0/1,
//   rd_swap, tw_idx = {start index, level}, wr_valid, wr_addr0/1, wr_swap.
// Option: define NTT_ADDR_STALL_EN to add the stall input.
module ntt_addr_gen
  import ntt_pkg::*;
#(
  parameter int unsigned LOG_N    = 6,
  parameter int unsigned ADDR_W   = 11,
  parameter int unsigned NTT_DLY  = 6,
  parameter int unsigned INTT_DLY = 7
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  mode,
  input  logic [ADDR_W-1:0]                     addr_bias,
`ifdef NTT_ADDR_STALL_EN
  input  logic                                  stall,
`endif
  output logic                                  busy,
  output logic                                  done,
  output logic                                  rd_valid,
  output logic [ADDR_W-1:0]                     rd_addr0,
  output logic [ADDR_W-1:0]                     rd_addr1,
  output logic                                  rd_swap,
  output logic [LOG_N+ntt_level_w(LOG_N)-1:0]   tw_idx,
  output logic                                  wr_valid,
  output logic [ADDR_W-1:0]                     wr_addr0,
  output logic [ADDR_W-1:0]                     wr_addr1,
  output logic                                  wr_swap
);

  localparam int unsigned LW = ntt_level_w(LOG_N);
  localparam int unsigned JW = LOG_N - 1;
  localparam int unsigned TW = LOG_N + LW;
  localparam int unsigned PW = 2 * ADDR_W + 2;
  localparam int unsigned CW = $clog2(INTT_DLY + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_e;

  state_e            state_q, state_d;
  ntt_mode_e         mode_q, mode_d;
  logic [ADDR_W-1:0] bias_q, bias_d;
  logic [JW-1:0]     j_q, j_d;
  logic [LW-1:0]     lvl_q, lvl_d;
  logic [CW-1:0]     dcnt_q, dcnt_d;
  logic [CW-1:0]     drain_len;
  logic              busy_d, done_d, rd_valid_d, rd_swap_d;
  logic              wr_swap_q, wr_swap_d;
  logic [ADDR_W-1:0] rd_addr0_d, rd_addr1_d;
  logic [TW-1:0]     tw_idx_d;
  logic              stall_w;

  // Butterfly fields for the slot currently held in (lvl_q, j_q).
  logic [ADDR_W-1:0] slot_addr0, slot_addr1;
  logic              slot_rd_swap, slot_wr_swap;
  logic [TW-1:0]     slot_tw;

`ifdef NTT_ADDR_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  assign slot_addr0   = bias_q + ADDR_W'(j_q);
  assign slot_addr1   = bias_q + ADDR_W'(32'(j_q) ^ ntt_mask(mode_q, LOG_N, 32'(lvl_q)));
  assign slot_rd_swap = ntt_rd_swap(mode_q, LOG_N, 32'(lvl_q), 32'(j_q));
  assign slot_wr_swap = ntt_wr_swap(mode_q, LOG_N, 32'(lvl_q), 32'(j_q));
  assign slot_tw      = {LOG_N'(ntt_tw_start(mode_q, LOG_N, 32'(lvl_q), 32'(j_q))), lvl_q};

  // Drain until the last issued slot has reached the write port.
  assign drain_len = (mode_q == MODE_INTT) ? CW'(INTT_DLY) : CW'(NTT_DLY);

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    bias_d     = bias_q;
    j_d        = j_q;
    lvl_d      = lvl_q;
    dcnt_d     = dcnt_q;
    busy_d     = busy;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;
    rd_addr0_d = rd_addr0;
    rd_addr1_d = rd_addr1;
    rd_swap_d  = rd_swap;
    tw_idx_d   = tw_idx;
    wr_swap_d  = wr_swap_q;
    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d = ST_RUN;
          mode_d  = mode ? MODE_INTT : MODE_NTT;
          bias_d  = addr_bias;
          j_d     = '0;
          lvl_d   = '0;
        end
      end
      ST_RUN: begin
        busy_d = 1'b1;
        if (!stall_w) begin
          rd_valid_d = 1'b1;
          rd_addr0_d = slot_addr0;
          rd_addr1_d = slot_addr1;
          rd_swap_d  = slot_rd_swap;
          tw_idx_d   = slot_tw;
          wr_swap_d  = slot_wr_swap;
          if (&j_q) begin
            j_d = '0;
            if (lvl_q == LW'(LOG_N - 1)) begin
              state_d = ST_DRAIN;
              dcnt_d  = '0;
            end else begin
              lvl_d = lvl_q + LW'(1);
            end
          end else begin
            j_d = j_q + JW'(1);
          end
        end
      end
      ST_DRAIN: begin
        busy_d = 1'b1;
        if (dcnt_q == drain_len) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          dcnt_d = dcnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_NTT;
      bias_q    <= '0;
      j_q       <= '0;
      lvl_q     <= '0;
      dcnt_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_valid  <= 1'b0;
      rd_addr0  <= '0;
      rd_addr1  <= '0;
      rd_swap   <= 1'b0;
      tw_idx    <= '0;
      wr_swap_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      bias_q    <= bias_d;
      j_q       <= j_d;
      lvl_q     <= lvl_d;
      dcnt_q    <= dcnt_d;
      busy      <= busy_d;
      done      <= done_d;
      rd_valid  <= rd_valid_d;
      rd_addr0  <= rd_addr0_d;
      rd_addr1  <= rd_addr1_d;
      rd_swap   <= rd_swap_d;
      tw_idx    <= tw_idx_d;
      wr_swap_q <= wr_swap_d;
    end
  end

  // Write-back copy of the registered read slot, delayed per latched mode.
  logic [PW-1:0] wb_din, wb_dout;

  assign wb_din = {rd_valid, rd_addr0, rd_addr1, wr_swap_q};

  ntt_delay_line #(
    .W    (PW),
    .DEPTH(INTT_DLY),
    .TAP_A(NTT_DLY),
    .TAP_B(INTT_DLY)
  ) u_wb_dly (
    .clk (clk),
    .clr (rst),
    .sel (mode_q == MODE_INTT),
    .din (wb_din),
    .dout(wb_dout)
  );

  assign {wr_valid, wr_addr0, wr_addr1, wr_swap} = wb_dout;

endmodule

// File: tb/tb_ntt_addr_gen.sv
// Bench for ntt_addr_gen (LOG_N=6, ADDR_W=11, NTT_DLY=6, INTT_DLY=7).
// A negedge monitor logs every read/write slot; directed vectors index into
// those logs by slot number (L*32 + j). Stall scenario only with NTT_ADDR_STALL_EN.
module tb_ntt_addr_gen;

  localparam int ADDR_W = 11;
  localparam int TW     = 9;

  logic              clk = 1'b0;
  logic              rst, start, mode;
  logic [ADDR_W-1:0] addr_bias;
`ifdef NTT_ADDR_STALL_EN
  logic              stall;
`endif
  logic              busy, done, rd_valid, rd_swap, wr_valid, wr_swap;
  logic [ADDR_W-1:0] rd_addr0, rd_addr1, wr_addr0, wr_addr1;
  logic [TW-1:0]     tw_idx;

  ntt_addr_gen dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .addr_bias(addr_bias),
`ifdef NTT_ADDR_STALL_EN
    .stall    (stall),
`endif
    .busy     (busy),
    .done     (done),
    .rd_valid (rd_valid),
    .rd_addr0 (rd_addr0),
    .rd_addr1 (rd_addr1),
    .rd_swap  (rd_swap),
    .tw_idx   (tw_idx),
    .wr_valid (wr_valid),
    .wr_addr0 (wr_addr0),
    .wr_addr1 (wr_addr1),
    .wr_swap  (wr_swap)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int a0;
    int a1;
    int sw;
    int tw;
  } rec_t;

  rec_t rd_q[$];
  rec_t wr_q[$];
  int   done_cnt = 0;

  always @(negedge clk) begin
    if (rd_valid) rd_q.push_back('{cyc, int'(rd_addr0), int'(rd_addr1), int'(rd_swap), int'(tw_idx)});
    if (wr_valid) wr_q.push_back('{cyc, int'(wr_addr0), int'(wr_addr1), int'(wr_swap), 0});
    if (done) done_cnt++;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic md;
    int   bias;
    int   lvl;
    int   j;
    int   a0;
    int   a1;
    int   rsw;
    int   wsw;
    int   tw;
  } vec_t;

  vec_t vt[10];

  task automatic pulse_start(input logic md, input int b, output int s);
    mode      = md;
    addr_bias = ADDR_W'(b);
    start     = 1'b1;
    s         = cyc + 1;
    @(posedge clk); #1;
    start     = 1'b0;
    mode      = ~md;
    addr_bias = ADDR_W'(b + 333);
  endtask

  task automatic wait_done(output int d);
    d = -1;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk); #1;
      if (done) begin
        d = cyc;
        break;
      end
    end
    if (d < 0) chk("done_seen", 0, 1);
  endtask

  task automatic check_run(input logic md, input int s, input int d);
    int dly;
    dly = md ? 7 : 6;
    chk("rd_count", rd_q.size(), 192);
    chk("wr_count", wr_q.size(), 192);
    chk("busy_at_done", busy, 0);
    chk("done_latency", d - s, 193 + dly);
    if (rd_q.size() == 192 && wr_q.size() == 192) begin
      chk("rd_first_cycle", rd_q[0].cyc, s + 1);
      chk("rd_contiguous", rd_q[191].cyc - rd_q[0].cyc, 191);
      chk("wr_first_cycle", wr_q[0].cyc, s + 1 + dly);
      chk("done_after_last_wr", d, wr_q[191].cyc + 1);
    end
  endtask

  task automatic do_run(input logic md, input int b);
    int s, d;
    rd_q.delete();
    wr_q.delete();
    pulse_start(md, b, s);
    wait_done(d);
    if (d >= 0) check_run(md, s, d);
    @(posedge clk); #1;
    chk("done_pulse_width", done, 0);
  endtask

  task automatic check_vec(input int i);
    int k, dly;
    k   = vt[i].lvl * 32 + vt[i].j;
    dly = vt[i].md ? 7 : 6;
    if (k < rd_q.size() && k < wr_q.size()) begin
      chk($sformatf("v%0d_rd_addr0", i), rd_q[k].a0, vt[i].a0);
      chk($sformatf("v%0d_rd_addr1", i), rd_q[k].a1, vt[i].a1);
      chk($sformatf("v%0d_rd_swap", i), rd_q[k].sw, vt[i].rsw);
      chk($sformatf("v%0d_tw_idx", i), rd_q[k].tw, vt[i].tw);
      chk($sformatf("v%0d_wr_addr0", i), wr_q[k].a0, vt[i].a0);
      chk($sformatf("v%0d_wr_addr1", i), wr_q[k].a1, vt[i].a1);
      chk($sformatf("v%0d_wr_swap", i), wr_q[k].sw, vt[i].wsw);
      chk($sformatf("v%0d_wr_delay", i), wr_q[k].cyc - rd_q[k].cyc, dly);
    end else begin
      chk($sformatf("v%0d_slot_present", i), 0, 1);
    end
  endtask

  initial begin
    int s, s2, d, d1, d2, w, dc, cur_md, cur_bias;

    //          md    bias  L  j   a0   a1   rsw wsw tw
    vt[0] = '{1'b0,    0, 0,  0,   0,   0,  0,  0,   0};
    vt[1] = '{1'b0,    0, 1,  0,   0,  16,  0,  0,   1};
    vt[2] = '{1'b0,    0, 1, 17,  17,   1,  1,  0, 257};
    vt[3] = '{1'b0,    0, 3, 13,  13,  17,  1,  0, 195};
    vt[4] = '{1'b0,    0, 5, 31,  31,   0,  1,  0, 501};
    vt[5] = '{1'b1,  100, 2,  5, 105, 106,  0,  1,  66};
    vt[6] = '{1'b1,  100, 0,  9, 109, 109,  0,  1, 144};
    vt[7] = '{1'b1,  100, 5, 22, 122, 109,  1,  0,   5};
    vt[8] = '{1'b0, 2040, 0, 10,   2,   2,  0,  0,   0};
    vt[9] = '{1'b0, 2040, 2, 10,   2,  10,  1,  0, 130};

    rst = 1'b1; start = 1'b0; mode = 1'b0; addr_bias = '0;
`ifdef NTT_ADDR_STALL_EN
    stall = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {busy, done, rd_valid, rd_addr0, rd_addr1, rd_swap, tw_idx,
                          wr_valid, wr_addr0, wr_addr1, wr_swap}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of level 3.
    rd_q.delete(); wr_q.delete();
    pulse_start(1'b0, 0, s);
    w = 0;
    while (rd_q.size() < 97 && w < 400) begin
      @(posedge clk); #1;
      w++;
    end
    chk("midrun_reached_l3", rd_q.size() >= 97, 1);
    chk("midrun_level", tw_idx[2:0], 3);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrun_reset_outputs", {busy, done, rd_valid, rd_addr0, rd_addr1, rd_swap, tw_idx,
                                 wr_valid, wr_addr0, wr_addr1, wr_swap}, 0);
    rst = 1'b0;
    dc  = done_cnt;
    repeat (20) @(posedge clk);
    #1;
    chk("midrun_no_done", done_cnt - dc, 0);
    chk("midrun_idle_busy", busy, 0);
    chk("midrun_idle_valid", {rd_valid, wr_valid}, 0);

    // Directed vectors; a new transform is run whenever mode or bias changes.
    cur_md = -1; cur_bias = -1;
    for (int i = 0; i < 10; i++) begin
      if (int'(vt[i].md) != cur_md || vt[i].bias != cur_bias) begin
        cur_md   = int'(vt[i].md);
        cur_bias = vt[i].bias;
        do_run(vt[i].md, vt[i].bias);
      end
      check_vec(i);
    end

    // Start during busy is ignored; start in the done cycle is accepted.
    rd_q.delete(); wr_q.delete();
    pulse_start(1'b0, 0, s);
    repeat (40) @(posedge clk);
    #1;
    mode = 1'b1; addr_bias = ADDR_W'(500); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(d1);
    mode = 1'b1; addr_bias = ADDR_W'(100); start = 1'b1;
    s2 = cyc + 1;
    if (d1 >= 0) check_run(1'b0, s, d1);
    if (rd_q.size() > 100) begin
      chk("b2b_ignored_addr0", rd_q[100].a0, 4);
      chk("b2b_ignored_addr1", rd_q[100].a1, 24);
    end else begin
      chk("b2b_slot100_present", 0, 1);
    end
    rd_q.delete(); wr_q.delete();
    @(posedge clk); #1;
    start = 1'b0; mode = 1'b0; addr_bias = '0;
    chk("b2b_done_pulse_width", done, 0);
    wait_done(d2);
    if (d2 >= 0) check_run(1'b1, s2, d2);
    if (rd_q.size() > 5) begin
      chk("b2b_second_addr0", rd_q[0].a0, 100);
      chk("b2b_second_l2j5_addr1", rd_q[69].a1, 106);
    end else begin
      chk("b2b_second_present", 0, 1);
    end
    @(posedge clk); #1;

`ifdef NTT_ADDR_STALL_EN
    // Stall 5 cycles while slot L=2, j=7 is pending.
    rd_q.delete(); wr_q.delete();
    pulse_start(1'b0, 0, s);
    repeat (71) @(posedge clk);
    #1;
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d_rd_valid", k), rd_valid, 0);
      chk($sformatf("stall%0d_rd_addr0_hold", k), rd_addr0, 6);
    end
    stall = 1'b0;
    wait_done(d);
    chk("stall_rd_count", rd_q.size(), 192);
    chk("stall_done_latency", d - s, 193 + 6 + 5);
    if (rd_q.size() == 192 && wr_q.size() == 192) begin
      chk("stall_rd_gap", rd_q[71].cyc - rd_q[70].cyc, 6);
      chk("stall_wr_gap", wr_q[71].cyc - wr_q[70].cyc, 6);
      chk("stall_resume_addr0", rd_q[71].a0, 7);
      chk("stall_wr_delay", wr_q[71].cyc - rd_q[71].cyc, 6);
    end
    @(posedge clk); #1;
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ntt_addr_gen.md
# ntt_addr_gen

Parametrised NTT/INTT butterfly address and control sequencer. It is the successor of the fixed 64-point, 6-level NTT counter. After a start handshake it walks all stages of an N-point transform, one butterfly per cycle, and produces:
- per-cycle read addresses, bank-swap flags and twiddle index;
- a mode-dependent delayed write-back copy for the polynomial memory banks;
- busy/done status for the server controller.

## Interface
- `LOG_N`, 6: log2 of transform size; N = 2^LOG_N; butterflies per level B = 2^(LOG_N-1); levels = LOG_N
- `ADDR_W`, 11: address width
- `NTT_DLY`, 6: read-to-write latency in cycles, NTT mode
- `INTT_DLY`, 7: read-to-write latency in cycles, INTT mode (≥ NTT_DLY)
- `clk` in 1: clock
- `rst` in 1: synchronous, active-high reset
- `start` in 1: start pulse; sampled only in IDLE
- `mode` in 1: 0 = NTT, 1 = INTT; latched with `start`
- `addr_bias` in ADDR_W: base address; latched with `start`
- `stall` in 1: present only with NTT_ADDR_STALL_EN
- `busy` out 1: high from accepted start until done
- `done` out 1: one-cycle pulse at completion
- `rd_valid` out 1: read slot valid
- `rd_addr0`, `rd_addr1` out ADDR_W: butterfly operand addresses
- `rd_swap` out 1: read-bank swap
- `tw_idx` out LOG_N+LW: {start_index[LOG_N-1:0], level[LW-1:0]}, where LW = $clog2(LOG_N)
- `wr_valid` out 1: write slot valid
- `wr_addr0`, `wr_addr1` out ADDR_W: write-back addresses
- `wr_swap` out 1: write-bank swap

## Operation
- States:
  - IDLE → RUN on `start`; latches mode and bias; clears level L and butterfly index j.
  - RUN: each cycle one butterfly issues. j increments; when j = B-1, j wraps to 0 and L increments. When L = LOG_N-1 and j = B-1, go to DRAIN.
  - DRAIN: waits until the last issued slot reaches `wr_valid`. Then `done` pulses and the block returns to IDLE.
- `start` is ignored while `busy`. `mode` and `addr_bias` changes during busy are ignored.
- Address rules (LOG_N-1-bit j; all sums are modulo 2^ADDR_W, wrapping silently):
  - `rd_addr0` = bias + j.
  - `rd_addr1` = bias + (j XOR M).
    - NTT: M = ((1<<L)-1) << (LOG_N-1-L), i.e. top L bits inverted.
    - INTT: M = (1<<L)-1, i.e. low L bits inverted.
- Swap rules:
  - NTT: rd_swap = j[LOG_N-1-L] for L≥1, else 0. Write swap = j[LOG_N-2-L] for L<LOG_N-1, else 0.
  - INTT: rd_swap = j[L-1] for L≥1, else 0. Write swap = j[L] for L<LOG_N-1, else 0.
- Twiddle start index S (LOG_N bits):
  - NTT: S = (j >> (LOG_N-1-L)) << (LOG_N-L).
  - INTT: the same formula, evaluated with L' = LOG_N-1-L.
- Write path: {valid, addr0, addr1, write swap} is delayed by NTT_DLY or INTT_DLY according to the latched mode.
- Reset at any time, including mid-transform: state IDLE; every output 0; delay line cleared.

## Timing
- All outputs are registered.
- `start` accepted at edge 0. `busy`, `rd_valid` and the first read slot (L=0, j=0) appear from edge 1.
- `rd_valid` stays high for exactly LOG_N·B consecutive cycles (192 for LOG_N=6) absent stall.
- `wr_*` slot k appears exactly DLY cycles after read slot k.
- `done` is high the cycle after the last `wr_valid`. `busy` falls in the same cycle as `done`.
- Earliest next `start` is accepted in the cycle `done` is high; that transform's first read appears at the next edge.

## Configuration
- `NTT_ADDR_STALL_EN` defined:
  - `stall` port exists.
  - While `stall`=1 in RUN: j, L and the read outputs hold, and `rd_valid`=0.
  - The delay line keeps shifting, so bubbles propagate as `wr_valid`=0.
  - Stall in IDLE or DRAIN has no effect.
- Undefined: no `stall` port; RUN issues every cycle.

## Structure
- Shared package `ntt_pkg`:
  - mode typedef (NTT/INTT);
  - level-width function;
  - NTT/INTT mask, swap-bit and twiddle-start functions, shared with the butterfly datapath and the memory controller.
- Sub-module `ntt_delay_line`:
  - parametrised width and depth; synchronous clear;
  - two taps (NTT_DLY, INTT_DLY), selected by the latched mode;
  - instanced once for the write-back bundle.

## Test plan
- Reset, then NTT start, LOG_N=6, bias=0:
  - L=1, j=0 → rd_addr0=0, rd_addr1=16, rd_swap=0.
  - L=1, j=17 → tw_idx = {6'b100000, 3'b001}.
  - Exactly 192 rd_valid cycles.
- INTT, bias=100, L=2, j=5 → rd_addr0=105, rd_addr1=106, rd_swap=0, write swap=1. wr_addr pair appears 7 cycles later.
- Back-to-back: second `start` during busy is ignored. `start` in the `done` cycle is accepted, and its first rd_valid follows at the next edge.
- Bias=2040, j=10 → rd_addr0 wraps to 2 (11-bit modulo).
- Assert `rst` mid-RUN at L=3 → next cycle all outputs 0 and IDLE; no `done` pulse.
- With NTT_ADDR_STALL_EN: stall 5 cycles at L=2, j=7 → rd outputs hold; wr_valid shows a 5-cycle gap NTT_DLY later; done is delayed by 5 cycles.
